// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control slice: opcodes, functs,
// ALU ops, datapath select codes, FSM states and the decoder payload.
package mips_pkg;

    localparam int unsigned IR_W  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 3;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTIU = 6'b001011;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [OP_W-1:0] ALU_AND  = 3'b000;
    localparam logic [OP_W-1:0] ALU_OR   = 3'b001;
    localparam logic [OP_W-1:0] ALU_XOR  = 3'b010;
    localparam logic [OP_W-1:0] ALU_NOR  = 3'b011;
    localparam logic [OP_W-1:0] ALU_ADD  = 3'b100;
    localparam logic [OP_W-1:0] ALU_SUB  = 3'b101;
    localparam logic [OP_W-1:0] ALU_SLTU = 3'b110;
    localparam logic [OP_W-1:0] ALU_SLLV = 3'b111;

    localparam logic [1:0] PC_S_PC4 = 2'b00;
    localparam logic [1:0] PC_S_BR  = 2'b10;
    localparam logic [1:0] PC_S_JMP = 2'b11;

    localparam logic [1:0] WRS_RD = 2'b00;
    localparam logic [1:0] WRS_RT = 2'b01;
    localparam logic [1:0] WRS_RA = 2'b10;

    localparam logic [1:0] WDS_ALU = 2'b00;
    localparam logic [1:0] WDS_MEM = 2'b01;
    localparam logic [1:0] WDS_PC4 = 2'b10;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_IARITH = 3'd1,
        CLS_LW     = 3'd2,
        CLS_SW     = 3'd3,
        CLS_BEQ    = 3'd4,
        CLS_BNE    = 3'd5,
        CLS_J      = 3'd6,
        CLS_JAL    = 3'd7
    } cls_e;

    typedef struct packed {
        cls_e            cls;
        logic [OP_W-1:0] op;
        logic            imm_s;
        logic            rt_imm_s;
        logic [1:0]      w_r_s;
        logic [1:0]      wr_data_s;
        logic            legal;
    } dec_t;

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction classifier: opcode/funct to class, ALU op and
// datapath selects, plus a legality flag for the trap path.
module mips_mc_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o       = '0;
        dec_o.legal = 1'b1;
        case (opcode_i)
            OPC_RTYPE: begin
                dec_o.cls = CLS_R;
                case (funct_i)
                    FN_ADD:  dec_o.op = ALU_ADD;
                    FN_SUB:  dec_o.op = ALU_SUB;
                    FN_AND:  dec_o.op = ALU_AND;
                    FN_OR:   dec_o.op = ALU_OR;
                    FN_XOR:  dec_o.op = ALU_XOR;
                    FN_NOR:  dec_o.op = ALU_NOR;
                    FN_SLTU: dec_o.op = ALU_SLTU;
                    FN_SLLV: dec_o.op = ALU_SLLV;
                    default: dec_o.legal = 1'b0;
                endcase
            end
            OPC_ADDI, OPC_ANDI, OPC_XORI, OPC_SLTIU: begin
                dec_o.cls      = CLS_IARITH;
                dec_o.rt_imm_s = 1'b1;
                dec_o.w_r_s    = WRS_RT;
                case (opcode_i)
                    OPC_ADDI: begin
                        dec_o.op    = ALU_ADD;
                        dec_o.imm_s = 1'b1;
                    end
                    OPC_ANDI: dec_o.op = ALU_AND;
                    OPC_XORI: dec_o.op = ALU_XOR;
                    default:  dec_o.op = ALU_SLTU;
                endcase
            end
            OPC_LW, OPC_SW: begin
                dec_o.cls       = (opcode_i == OPC_LW) ? CLS_LW : CLS_SW;
                dec_o.op        = ALU_ADD;
                dec_o.imm_s     = 1'b1;
                dec_o.rt_imm_s  = 1'b1;
                dec_o.w_r_s     = WRS_RT;
                dec_o.wr_data_s = WDS_MEM;
            end
            OPC_BEQ, OPC_BNE: begin
                dec_o.cls = (opcode_i == OPC_BEQ) ? CLS_BEQ : CLS_BNE;
                dec_o.op  = ALU_SUB;
            end
            OPC_J:   dec_o.cls = CLS_J;
            OPC_JAL: begin
                dec_o.cls       = CLS_JAL;
                dec_o.w_r_s     = WRS_RA;
                dec_o.wr_data_s = WDS_PC4;
            end
            default: dec_o.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: instruction register, FETCH..WB FSM with
// memory handshakes, registered request strobes and a sticky illegal trap.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RA_ADDR   = 31,
    parameter int unsigned TRAP_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_ack_i,
    input  logic [IR_W-1:0]   imem_rdata_i,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic              imem_req_o,
    output logic              dmem_req_o,
    output logic              mem_write_o,
    output logic              pc_write_o,
    output logic [1:0]        pc_s_o,
    output logic [REG_W-1:0]  rs_o,
    output logic [REG_W-1:0]  rt_o,
    output logic [REG_W-1:0]  rd_o,
    output logic [15:0]       imm_offset_o,
    output logic [25:0]       addressb_o,
    output logic [1:0]        w_r_s_o,
    output logic [1:0]        wr_data_s_o,
    output logic              imm_s_o,
    output logic              rt_imm_s_o,
    output logic [OP_W-1:0]   op_o,
    output logic              write_reg_o,
    output logic              illegal_o,
    output logic [2:0]        state_o
);

    // The jal link register index must fit the 5-bit register file address.
    if (RA_ADDR >= 32 || DATA_W == 0) begin : g_bad_param
        $error("mips_mc_ctrl: RA_ADDR must be < 32 and DATA_W > 0");
    end

    state_e            state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic              imem_req_q, dmem_req_q, mem_write_q, illegal_q;
    dec_t              dec;
    logic              zero_c;

    mips_mc_decode u_dec (
        .opcode_i (ir_q[31:26]),
        .funct_i  (ir_q[5:0]),
        .dec_o    (dec)
    );

    assign zero_c = ~|alu_result_i;

    // Next-state and IR load; acks only count while the matching req is up.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            FETCH: begin
                if (imem_req_q && imem_ack_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = dec.legal ? EXEC : TRAP;
            EXEC: begin
                case (dec.cls)
                    CLS_R, CLS_IARITH: state_d = WB;
                    CLS_LW, CLS_SW:    state_d = MEM;
                    default:           state_d = FETCH;
                endcase
            end
            MEM: begin
                if (dmem_req_q && dmem_ack_i) begin
                    state_d = (dec.cls == CLS_LW) ? WB : FETCH;
                end
            end
            WB:      state_d = FETCH;
            TRAP:    state_d = (TRAP_HOLD != 0) ? TRAP : FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Request strobes are registered from the next state so reset drops them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            ir_q        <= '0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            mem_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            imem_req_q  <= (state_d == FETCH);
            dmem_req_q  <= (state_d == MEM);
            mem_write_q <= (state_d == MEM) && (dec.cls == CLS_SW);
            illegal_q   <= illegal_q || (state_d == TRAP);
        end
    end

    // Selects and one-cycle strobes that must line up with the datapath this cycle.
    always_comb begin
        pc_s_o      = PC_S_PC4;
        op_o        = '0;
        imm_s_o     = 1'b0;
        rt_imm_s_o  = 1'b0;
        w_r_s_o     = WRS_RD;
        wr_data_s_o = WDS_ALU;
        pc_write_o  = 1'b0;
        write_reg_o = 1'b0;
        if (state_q inside {DECODE, EXEC, MEM, WB}) begin
            op_o       = dec.op;
            imm_s_o    = dec.imm_s;
            rt_imm_s_o = dec.rt_imm_s;
        end
        if (state_q == EXEC || state_q == WB) begin
            w_r_s_o     = dec.w_r_s;
            wr_data_s_o = dec.wr_data_s;
        end
        case (state_q)
            FETCH: pc_write_o = imem_req_q && imem_ack_i;
            EXEC: begin
                case (dec.cls)
                    CLS_BEQ: begin
                        pc_s_o     = PC_S_BR;
                        pc_write_o = zero_c;
                    end
                    CLS_BNE: begin
                        pc_s_o     = PC_S_BR;
                        pc_write_o = ~zero_c;
                    end
                    CLS_J: begin
                        pc_s_o     = PC_S_JMP;
                        pc_write_o = 1'b1;
                    end
                    CLS_JAL: begin
                        pc_s_o      = PC_S_JMP;
                        pc_write_o  = 1'b1;
                        write_reg_o = 1'b1;
                    end
                    default: ;
                endcase
            end
            WB:      write_reg_o = 1'b1;
            default: ;
        endcase
    end

    assign imem_req_o   = imem_req_q;
    assign dmem_req_o   = dmem_req_q;
    assign mem_write_o  = mem_write_q;
    assign illegal_o    = illegal_q;
    assign state_o      = state_q;
    assign rs_o         = ir_q[25:21];
    assign rt_o         = ir_q[20:16];
    assign rd_o         = ir_q[15:11];
    assign imm_offset_o = ir_q[15:0];
    assign addressb_o   = ir_q[25:0];

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed-vector bench for mips_mc_ctrl: one task per scenario, expected
// values hand-derived from the instruction encodings.
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_ack;
    logic [31:0] alu_result;
    logic        imem_req, dmem_req, mem_write, pc_write;
    logic [1:0]  pc_s, w_r_s, wr_data_s;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm_offset;
    logic [25:0] addressb;
    logic        imm_s, rt_imm_s, write_reg, illegal;
    logic [2:0]  op, state;

    int n_tests = 0;
    int n_fail  = 0;
    int pcw_cnt = 0, wr_cnt = 0, dreq_cnt = 0, overlap_cnt = 0, mw_noreq_cnt = 0;
    logic       ack_pcw;
    logic [1:0] ack_pcs;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.DATA_W(32), .RA_ADDR(31), .TRAP_HOLD(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_ack_i   (imem_ack),
        .imem_rdata_i (imem_rdata),
        .dmem_ack_i   (dmem_ack),
        .alu_result_i (alu_result),
        .imem_req_o   (imem_req),
        .dmem_req_o   (dmem_req),
        .mem_write_o  (mem_write),
        .pc_write_o   (pc_write),
        .pc_s_o       (pc_s),
        .rs_o         (rs),
        .rt_o         (rt),
        .rd_o         (rd),
        .imm_offset_o (imm_offset),
        .addressb_o   (addressb),
        .w_r_s_o      (w_r_s),
        .wr_data_s_o  (wr_data_s),
        .imm_s_o      (imm_s),
        .rt_imm_s_o   (rt_imm_s),
        .op_o         (op),
        .write_reg_o  (write_reg),
        .illegal_o    (illegal),
        .state_o      (state)
    );

    always @(posedge clk) begin
        if (pc_write)               pcw_cnt      <= pcw_cnt + 1;
        if (write_reg)              wr_cnt       <= wr_cnt + 1;
        if (dmem_req)               dreq_cnt     <= dreq_cnt + 1;
        if (write_reg && mem_write) overlap_cnt  <= overlap_cnt + 1;
        if (mem_write && !dmem_req) mw_noreq_cnt <= mw_noreq_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for imem_req, ack after 'waits' idle cycles, end in DECODE.
    task automatic fetch(input logic [31:0] instr, input int waits);
        int k = 0;
        while (!imem_req && k < 20) begin
            cyc();
            k++;
        end
        n_tests++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_req_timeout: imem_req=%0b required 1", imem_req);
        end
        imem_ack = 1'b0;
        repeat (waits) cyc();
        imem_ack   = 1'b1;
        imem_rdata = instr;
        #1;
        ack_pcw = pc_write;
        ack_pcs = pc_s;
        cyc();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; alu_result = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({imem_req, dmem_req, mem_write, pc_write, write_reg, illegal} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b required 000000",
                     {imem_req, dmem_req, mem_write, pc_write, write_reg, illegal});
        end
        n_tests++;
        if ({pc_s, w_r_s, wr_data_s, imm_s, rt_imm_s, op, state} !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_selects: got %b required 0",
                     {pc_s, w_r_s, wr_data_s, imm_s, rt_imm_s, op, state});
        end
        n_tests++;
        if ({rs, rt, rd, imm_offset, addressb} !== 57'b0) begin
            n_fail++;
            $display("FAIL reset_fields: got %h required 0", {rs, rt, rd, imm_offset, addressb});
        end
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0022_1820;
        #1;
        n_tests++;
        if ({imem_req, pc_write} !== 2'b00) begin
            n_fail++;
            $display("FAIL stray_ack: {imem_req,pc_write}=%b required 00", {imem_req, pc_write});
        end
        cyc();
        imem_ack = 1'b0;
        n_tests++;
        if ({state, imem_req} !== {3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_fetch: state=%0d imem_req=%0b required 0/1", state, imem_req);
        end
    endtask

    task automatic test_add();
        int pcw0 = pcw_cnt;
        int wr0  = wr_cnt;
        fetch(32'h0022_1820, 2);
        n_tests++;
        if ({ack_pcw, ack_pcs} !== 3'b100) begin
            n_fail++;
            $display("FAIL add_fetch_pcw: pc_write/pc_s=%b required 100", {ack_pcw, ack_pcs});
        end
        n_tests++;
        if ({state, rs, rt, rd, op} !== {3'd1, 5'd1, 5'd2, 5'd3, 3'b100}) begin
            n_fail++;
            $display("FAIL add_decode: state=%0d rs=%0d rt=%0d rd=%0d op=%b required 1/1/2/3/100",
                     state, rs, rt, rd, op);
        end
        cyc();
        n_tests++;
        if ({state, write_reg} !== {3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL add_exec: state=%0d write_reg=%0b required 2/0", state, write_reg);
        end
        cyc();
        n_tests++;
        if ({state, write_reg, w_r_s, wr_data_s} !== {3'd4, 1'b1, 2'b00, 2'b00}) begin
            n_fail++;
            $display("FAIL add_wb: state=%0d wr=%0b w_r_s=%b wd=%b required 4/1/00/00",
                     state, write_reg, w_r_s, wr_data_s);
        end
        cyc();
        n_tests++;
        if ({state, write_reg, pcw_cnt - pcw0, wr_cnt - wr0} !== {3'd0, 1'b0, 32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL add_counts: state=%0d pc_writes=%0d reg_writes=%0d required 0/1/1",
                     state, pcw_cnt - pcw0, wr_cnt - wr0);
        end
    endtask

    task automatic test_lw();
        int dreq0;
        fetch(32'h8C22_0004, 0);
        n_tests++;
        if ({op, imm_s, rt_imm_s, imm_offset} !== {3'b100, 1'b1, 1'b1, 16'h0004}) begin
            n_fail++;
            $display("FAIL lw_decode: op=%b imm_s=%0b rt_imm_s=%0b imm=%h required 100/1/1/0004",
                     op, imm_s, rt_imm_s, imm_offset);
        end
        cyc();
        cyc();
        dreq0 = dreq_cnt;
        n_tests++;
        if ({state, dmem_req, mem_write} !== {3'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL lw_mem: state=%0d dmem_req=%0b mem_write=%0b required 3/1/0",
                     state, dmem_req, mem_write);
        end
        repeat (3) cyc();
        dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0;
        n_tests++;
        if ({state, dmem_req, write_reg, w_r_s, wr_data_s, imm_s} !==
            {3'd4, 1'b0, 1'b1, 2'b01, 2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL lw_wb: state=%0d req=%0b wr=%0b w_r_s=%b wd=%b imm_s=%0b required 4/0/1/01/01/1",
                     state, dmem_req, write_reg, w_r_s, wr_data_s, imm_s);
        end
        n_tests++;
        if (dreq_cnt - dreq0 !== 4) begin
            n_fail++;
            $display("FAIL lw_req_cycles: got %0d required 4", dreq_cnt - dreq0);
        end
        cyc();
    endtask

    task automatic test_sw();
        int wr0  = wr_cnt;
        int mwn0 = mw_noreq_cnt;
        fetch(32'hAC22_0004, 1);
        cyc();
        n_tests++;
        if ({state, mem_write} !== {3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL sw_exec: state=%0d mem_write=%0b required 2/0", state, mem_write);
        end
        cyc();
        n_tests++;
        if ({dmem_req, mem_write} !== 2'b11) begin
            n_fail++;
            $display("FAIL sw_mem: {dmem_req,mem_write}=%b required 11", {dmem_req, mem_write});
        end
        cyc();
        dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0;
        n_tests++;
        if ({state, dmem_req, mem_write} !== {3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sw_done: state=%0d req=%0b mw=%0b required 0/0/0", state, dmem_req, mem_write);
        end
        n_tests++;
        if ({wr_cnt - wr0, mw_noreq_cnt - mwn0} !== {32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL sw_no_write: reg_writes=%0d mw_without_req=%0d required 0/0",
                     wr_cnt - wr0, mw_noreq_cnt - mwn0);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [4] = '{32'h1022_0003, 32'h1022_0003, 32'h1422_0003, 32'h1422_0003};
        logic [31:0] alu [4] = '{32'd0, 32'd5, 32'd0, 32'd5};
        logic        tkn [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            int pcw0 = pcw_cnt;
            fetch(ins[i], 0);
            alu_result = alu[i];
            n_tests++;
            if ({op, rt_imm_s} !== {3'b101, 1'b0}) begin
                n_fail++;
                $display("FAIL br%0d_decode: op=%b rt_imm_s=%0b required 101/0", i, op, rt_imm_s);
            end
            cyc();
            n_tests++;
            if ({state, pc_write, pc_s} !== {3'd2, tkn[i], 2'b10}) begin
                n_fail++;
                $display("FAIL br%0d_exec: state=%0d pc_write=%0b pc_s=%b required 2/%0b/10",
                         i, state, pc_write, pc_s, tkn[i]);
            end
            cyc();
            alu_result = '0;
            n_tests++;
            if ({state, 32'(pcw_cnt - pcw0)} !== {3'd0, 32'(tkn[i]) + 32'd1}) begin
                n_fail++;
                $display("FAIL br%0d_done: state=%0d pc_writes=%0d required 0/%0d",
                         i, state, pcw_cnt - pcw0, tkn[i] + 1);
            end
        end
    endtask

    task automatic test_jump();
        fetch(32'h0C00_0010, 0);
        cyc();
        n_tests++;
        if ({pc_s, pc_write, write_reg, w_r_s, wr_data_s, addressb} !==
            {2'b11, 1'b1, 1'b1, 2'b10, 2'b10, 26'h000_0010}) begin
            n_fail++;
            $display("FAIL jal_exec: pc_s=%b pcw=%0b wr=%0b w_r_s=%b wd=%b addr=%h required 11/1/1/10/10/0000010",
                     pc_s, pc_write, write_reg, w_r_s, wr_data_s, addressb);
        end
        cyc();
        n_tests++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL jal_done: state=%0d required 0", state);
        end
        fetch(32'h0800_0020, 0);
        cyc();
        n_tests++;
        if ({pc_s, pc_write, write_reg, addressb} !== {2'b11, 1'b1, 1'b0, 26'h000_0020}) begin
            n_fail++;
            $display("FAIL j_exec: pc_s=%b pcw=%0b wr=%0b addr=%h required 11/1/0/0000020",
                     pc_s, pc_write, write_reg, addressb);
        end
        cyc();
    endtask

    task automatic test_alu_ops();
        logic [31:0] ins [8] = '{32'h0022_1822, 32'h0022_182B, 32'h0022_1804, 32'h0022_1827,
                                 32'h2022_FFFF, 32'h3022_000F, 32'h3822_000F, 32'h2C22_000F};
        logic [2:0]  eop [8] = '{3'b101, 3'b110, 3'b111, 3'b011, 3'b100, 3'b000, 3'b010, 3'b110};
        logic        eis [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        eri [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            fetch(ins[i], 0);
            n_tests++;
            if ({op, imm_s, rt_imm_s} !== {eop[i], eis[i], eri[i]}) begin
                n_fail++;
                $display("FAIL alu%0d_decode: op=%b imm_s=%0b rt_imm_s=%0b required %b/%0b/%0b",
                         i, op, imm_s, rt_imm_s, eop[i], eis[i], eri[i]);
            end
            cyc();
            cyc();
            n_tests++;
            if ({state, write_reg, w_r_s, wr_data_s} !== {3'd4, 1'b1, 1'b0, eri[i], 2'b00}) begin
                n_fail++;
                $display("FAIL alu%0d_wb: state=%0d wr=%0b w_r_s=%b wd=%b required 4/1/0%0b/00",
                         i, state, write_reg, w_r_s, wr_data_s, eri[i]);
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid_mem();
        fetch(32'h8C22_0004, 0);
        cyc();
        cyc();
        n_tests++;
        if (dmem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmem_pre: dmem_req=%0b required 1", dmem_req);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({imem_req, dmem_req, mem_write, pc_write, write_reg, illegal, state} !== 9'b0) begin
            n_fail++;
            $display("FAIL rstmem_drop: strobes/state=%b required 0",
                     {imem_req, dmem_req, mem_write, pc_write, write_reg, illegal, state});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_trap();
        fetch(32'hFC00_0000, 0);
        cyc();
        n_tests++;
        if ({state, illegal} !== {3'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL trap_enter: state=%0d illegal=%0b required 5/1", state, illegal);
        end
        imem_ack = 1'b1;
        repeat (5) cyc();
        #1;
        n_tests++;
        if ({state, illegal, imem_req, pc_write} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL trap_hold: state=%0d illegal=%0b req=%0b pcw=%0b required 5/1/0/0",
                     state, illegal, imem_req, pc_write);
        end
        imem_ack = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_tests++;
        if ({state, illegal} !== {3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL trap_reset: state=%0d illegal=%0b required 0/0", state, illegal);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fetch(32'h0000_0000, 0);
        cyc();
        n_tests++;
        if ({state, illegal} !== {3'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL trap_bad_funct: state=%0d illegal=%0b required 5/1", state, illegal);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_branch();
        test_jump();
        test_alu_ops();
        test_reset_mid_mem();
        test_trap();
        n_tests++;
        if (overlap_cnt !== 0) begin
            n_fail++;
            $display("FAIL write_reg_mem_write_overlap: got %0d cycles required 0", overlap_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS R/I/J datapath.
- Latches the fetched instruction into an internal IR and steps an FSM through FETCH/DECODE/EXEC/MEM/WB.
- Drives the same datapath select/strobe set as the single-cycle decoder, adding:
  - req/ack handshakes to instruction and data memory;
  - registered branch resolution;
  - an illegal-instruction trap.
- Sits between the memory ports and the PC / register-file / ALU muxes.

Parameters:
- DATA_W, 32, datapath width; sets the alu_result_zero reduction width.
- RA_ADDR, 31, register index written by jal.
- TRAP_HOLD, 1, 1 = stay in TRAP until reset; 0 = skip the opcode and refetch at PC+4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_ack  in  1  instruction memory data valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_ack  in  1  data memory access complete.
- alu_result  in  DATA_W  ALU output; zero is computed internally as ~|alu_result.
- imem_req  out  1  fetch request.
- dmem_req  out  1  data memory request.
- mem_write  out  1  store strobe, valid while dmem_req is high.
- pc_write  out  1  one-cycle PC load enable.
- pc_s  out  2  PC source: 00 = PC+4, 10 = branch target, 11 = jump target.
- rs, rt, rd  out  5 each  IR fields.
- imm_offset  out  16  IR[15:0].
- addressb  out  26  IR[25:0].
- w_r_s  out  2  write-register select: 00 = rd, 01 = rt, 10 = RA_ADDR.
- wr_data_s  out  2  write-data select: 00 = ALU, 01 = memory, 10 = PC+4.
- imm_s  out  1  1 = sign-extend, 0 = zero-extend.
- rt_imm_s  out  1  ALU B: 0 = rt, 1 = immediate.
- op  out  3  ALU operation.
- write_reg  out  1  register-file write enable, one cycle.
- illegal  out  1  sticky trap flag.
- state  out  3  FSM state, for debug.

Behaviour:
- Reset (async, rst_n low):
  - State goes to FETCH; IR is cleared to 0.
  - All strobes are 0: imem_req, dmem_req, mem_write, pc_write, write_reg, illegal.
  - All selects are 0.
  - Reset mid-transaction drops the req line immediately; no ack handling is required afterwards.
- Field outputs (rs/rt/rd/imm_offset/addressb) are taken from IR only and change only on the IR load.
- Select outputs are decoded combinationally from IR + state. Strobes are asserted only in the states listed below.
- FETCH:
  - imem_req = 1 until imem_ack.
  - On ack: load IR from imem_rdata, pulse pc_write with pc_s = 00, go to DECODE.
  - No timeout; the FSM waits indefinitely.
- DECODE (1 cycle), classifying IR:
  - R-type: op field 000000.
  - I-arith: op[5:3] = 001.
  - load/store: 100011 / 101011.
  - branch: 000100 / 000101.
  - jump: 000010 / 000011.
  - Anything else is illegal, including a listed class with an undecoded funct/opcode → TRAP.
  - All classes that are not illegal go to EXEC.
- ALU op map:
  - R-type funct: add 100000 → 100; sub 100010 → 101; and 100100 → 000; or 100101 → 001; xor 100110 → 010; nor 100111 → 011; sltu 101011 → 110; sllv 000100 → 111.
  - I-type: addi → 100 (imm_s = 1); andi → 000; xori → 010; sltiu → 110 (these three imm_s = 0).
  - lw / sw → 100, imm_s = 1.
  - beq / bne → 101, rt_imm_s = 0.
- EXEC (1 cycle):
  - R-type and I-arith → WB.
  - lw / sw → MEM.
  - beq: if zero, pulse pc_write with pc_s = 10; then → FETCH.
  - bne: the same when not zero.
  - j: pulse pc_write with pc_s = 11 → FETCH.
  - jal: pc_s = 11 plus write_reg with w_r_s = 10, wr_data_s = 10, same cycle → FETCH.
- MEM:
  - dmem_req = 1 (and mem_write = 1 for sw), held until dmem_ack.
  - On ack: sw → FETCH; lw → WB.
- WB (1 cycle): write_reg = 1.
  - R-type: w_r_s = 00, wr_data_s = 00.
  - I-arith: w_r_s = 01, wr_data_s = 00.
  - lw: w_r_s = 01, wr_data_s = 01.
  - Then → FETCH.
- TRAP: illegal = 1.
  - TRAP_HOLD = 1: remain in TRAP.
  - TRAP_HOLD = 0: one cycle in TRAP, illegal stays set, then → FETCH.
  - illegal is sticky until reset.
- Latency in cycles, excluding memory waits: R/I-arith 4; lw 5; sw 4; beq/bne/j/jal 3.
- An ack arriving when no req is outstanding is ignored.
- write_reg and mem_write are never high in the same cycle.

Decomposition:
- Shared package mips_pkg holds:
  - opcode/funct localparams;
  - ALU op codes (3 bit);
  - pc_s / w_r_s / wr_data_s encodings;
  - state encoding: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Sub-module mips_mc_decode: purely combinational IR → {class, op, imm_s, rt_imm_s, w_r_s, wr_data_s, legal}.
- mips_mc_ctrl holds the FSM, IR, and strobe generation.

Test Plan:
- Reset release, imem_ack after 2 wait cycles with 0x00221820 (add $3,$1,$2) → rs = 1, rt = 2, rd = 3, op = 100; write_reg one cycle in WB with w_r_s = 00; pc_write exactly once.
- 0x8C220004 (lw $2,4($1)), dmem_ack after 3 cycles → dmem_req high 4 cycles, mem_write = 0; WB has w_r_s = 01, wr_data_s = 01, imm_s = 1.
- 0xAC220004 (sw) → mem_write = 1 only while dmem_req is high; write_reg never asserted.
- 0x10220003 (beq): alu_result = 0 → second pc_write with pc_s = 10; alu_result = 5 → no second pc_write. 0x14220003 (bne) gives the inverse.
- 0x0C000010 (jal) → in EXEC: pc_s = 11, addressb = 0x0000010, write_reg = 1, w_r_s = 10, wr_data_s = 10.
- 0xFC000000 with TRAP_HOLD = 1 → illegal = 1 and the FSM stays in TRAP. Assert rst_n low mid-MEM → all strobes 0 immediately and state = FETCH.
